// File: rtl/freq_scaler_pkg.sv
// Shared constants and helpers for the multi-channel clock divider / tick generator.
// Half-period values assume a 50 MHz reference clock.
package freq_scaler_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_HALF_3M125 = 8;

    // Standard rates, expressed as half-periods of the 50 MHz clock
    localparam int HALF_3M125 = 8;
    localparam int HALF_1M    = 25;
    localparam int HALF_500K  = 50;

    function automatic int ch_width(input int num_ch);
        int w_v;
        if (num_ch > 1) begin
            w_v = $clog2(num_ch);
        end else begin
            w_v = 1;
        end
        return w_v;
    endfunction

endpackage

// File: rtl/freq_scaler_ch.sv
// One divider channel: counter, shadow/active half-period and glitch-free update.
// A new half-period only takes effect at the end of a full output period.
module freq_scaler_ch
    import freq_scaler_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_HALF = DEF_HALF_3M125
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] ZERO_V     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_V      = CNT_W'(1);

    logic [CNT_W-1:0] act_half_r, shd_half_r, cnt_r;
    logic             out_r, tick_r, pend_r;

    logic [CNT_W-1:0] act_nx_s, shd_nx_s, cnt_nx_s;
    logic             out_nx_s, tick_nx_s, pend_nx_s;
    logic             last_s;

    assign last_s = (cnt_r == (act_half_r - ONE_V));

    // Next-state selection: sync, then disabled reload, then period-end update, then counting
    always_comb begin
        act_nx_s  = act_half_r;
        shd_nx_s  = shd_half_r;
        cnt_nx_s  = cnt_r;
        out_nx_s  = out_r;
        tick_nx_s = 1'b0;
        pend_nx_s = pend_r;
        if (sync) begin
            cnt_nx_s  = ZERO_V;
            out_nx_s  = 1'b0;
            pend_nx_s = 1'b0;
            if (wr) begin
                act_nx_s = wr_half;
                shd_nx_s = wr_half;
            end else begin
                act_nx_s = shd_half_r;
            end
        end else if (act_half_r == ZERO_V) begin
            // Disabled channel: parked low, picks up a pending value one edge later
            cnt_nx_s = ZERO_V;
            out_nx_s = 1'b0;
            if (wr) begin
                shd_nx_s  = wr_half;
                pend_nx_s = 1'b1;
            end else if (pend_r) begin
                act_nx_s  = shd_half_r;
                pend_nx_s = 1'b0;
            end else begin
                act_nx_s = act_half_r;
            end
        end else if (last_s && out_r) begin
            cnt_nx_s  = ZERO_V;
            out_nx_s  = 1'b0;
            pend_nx_s = 1'b0;
            if (wr) begin
                act_nx_s = wr_half;
                shd_nx_s = wr_half;
            end else if (pend_r) begin
                act_nx_s = shd_half_r;
            end else begin
                act_nx_s = act_half_r;
            end
        end else begin
            if (last_s) begin
                cnt_nx_s  = ZERO_V;
                out_nx_s  = 1'b1;
                tick_nx_s = 1'b1;
            end else begin
                cnt_nx_s = cnt_r + ONE_V;
            end
            if (wr) begin
                shd_nx_s  = wr_half;
                pend_nx_s = 1'b1;
            end else begin
                pend_nx_s = pend_r;
            end
        end
    end

    // Channel state register with synchronous active-low reset
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            act_half_r <= DEF_HALF_V;
            shd_half_r <= DEF_HALF_V;
            cnt_r      <= ZERO_V;
            out_r      <= 1'b0;
            tick_r     <= 1'b0;
            pend_r     <= 1'b0;
        end else begin
            act_half_r <= act_nx_s;
            shd_half_r <= shd_nx_s;
            cnt_r      <= cnt_nx_s;
            out_r      <= out_nx_s;
            tick_r     <= tick_nx_s;
            pend_r     <= pend_nx_s;
        end
    end

    assign clk_out = out_r;
    assign tick    = tick_r;
    assign pending = pend_r;

endmodule

// File: rtl/freq_scaler_multi.sv
// Multi-channel programmable clock divider and tick generator on clk_50M.
// Decodes the channel write strobe and instantiates one divider per channel.
module freq_scaler_multi
    import freq_scaler_pkg::*;
#(
    parameter int  NUM_CH   = DEF_NUM_CH,
    parameter int  CNT_W    = DEF_CNT_W,
    parameter int  DEF_HALF = DEF_HALF_3M125,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] wr_sel_s;
    logic              in_range_s;

    assign in_range_s = ({1'b0, wr_ch} < NUM_CH_V);

    // One-hot write decode; indices beyond the last channel are dropped
    always_comb begin
        wr_sel_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && in_range_s && (wr_ch == CH_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        freq_scaler_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_50M (clk_50M),
            .rst_n   (rst_n),
            .sync    (sync),
            .wr      (wr_sel_s[g]),
            .wr_half (wr_half),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_freq_scaler_multi.sv
// Directed bench for freq_scaler_multi with five channels, so that wr_ch = 5 is
// representable as an out-of-range index.
module tb_freq_scaler_multi;

    localparam int NCH = 5;

    logic           clk_50M = 1'b0;
    logic           rst_n   = 1'b0;
    logic           sync    = 1'b0;
    logic           wr_en   = 1'b0;
    logic [2:0]     wr_ch   = 3'd0;
    logic [7:0]     wr_half = 8'd0;
    logic [NCH-1:0] clk_out, tick, pending;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    freq_scaler_multi #(.NUM_CH(NCH), .CNT_W(8), .DEF_HALF(8)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_half (wr_half),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic step();
        @(posedge clk_50M);
        #1;
        ecnt++;
    endtask

    task automatic write_step(input logic [2:0] ch, input logic [7:0] h);
        wr_en = 1'b1; wr_ch = ch; wr_half = h;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] exp_c, exp_t;
        int highs = 0;
        rst_n = 1'b0;
        step(); step();
        total++; if (clk_out !== 5'b00000) begin bad++; $display("FAIL reset_clk got=%b exp=%b", clk_out, 5'b00000); end
        total++; if (tick !== 5'b00000) begin bad++; $display("FAIL reset_tick got=%b exp=%b", tick, 5'b00000); end
        total++; if (pending !== 5'b00000) begin bad++; $display("FAIL reset_pend got=%b exp=%b", pending, 5'b00000); end
        rst_n = 1'b1;
        ecnt = 0;
        for (int e = 1; e <= 1008; e++) begin
            step();
            exp_c = ((ecnt / 8) % 2 == 1) ? 5'b11111 : 5'b00000;
            exp_t = (ecnt % 16 == 8) ? 5'b11111 : 5'b00000;
            total++; if (clk_out !== exp_c) begin bad++; $display("FAIL dflt_clk e=%0d got=%b exp=%b", ecnt, clk_out, exp_c); end
            total++; if (tick !== exp_t) begin bad++; $display("FAIL dflt_tick e=%0d got=%b exp=%b", ecnt, tick, exp_t); end
            if (e > 16 && clk_out[0] === 1'b1) highs++;
        end
        total++; if (highs !== 496) begin bad++; $display("FAIL duty got=%0d exp=%0d", highs, 496); end
    endtask

    task automatic test_write_mid_period();
        while (ecnt % 16 != 4) step();
        write_step(3'd1, 8'd25);
        while (ecnt % 16 != 0) begin
            total++; if (pending[1] !== 1'b1) begin bad++; $display("FAIL ch1_pend e=%0d got=%b exp=1", ecnt, pending[1]); end
            total++; if (clk_out[1] !== 1'((ecnt / 8) % 2)) begin bad++; $display("FAIL ch1_old e=%0d got=%b", ecnt, clk_out[1]); end
            step();
        end
        total++; if (pending[1] !== 1'b0) begin bad++; $display("FAIL ch1_applied got=%b exp=0", pending[1]); end
        for (int k = 1; k <= 100; k++) begin
            step();
            total++; if (clk_out[1] !== 1'((k / 25) % 2)) begin bad++; $display("FAIL ch1_clk k=%0d got=%b", k, clk_out[1]); end
            total++; if (tick[1] !== 1'(k % 50 == 25)) begin bad++; $display("FAIL ch1_tick k=%0d got=%b", k, tick[1]); end
        end
    endtask

    task automatic test_disable();
        write_step(3'd2, 8'd0);
        while (ecnt % 16 != 0) begin
            total++; if (pending[2] !== 1'b1) begin bad++; $display("FAIL ch2_pend e=%0d got=%b exp=1", ecnt, pending[2]); end
            total++; if (clk_out[2] !== 1'((ecnt / 8) % 2)) begin bad++; $display("FAIL ch2_old e=%0d got=%b", ecnt, clk_out[2]); end
            step();
        end
        total++; if (pending[2] !== 1'b0) begin bad++; $display("FAIL ch2_off_pend got=%b exp=0", pending[2]); end
        for (int k = 0; k < 20; k++) begin
            step();
            total++; if ({clk_out[2], tick[2]} !== 2'b00) begin bad++; $display("FAIL ch2_off k=%0d got=%b%b exp=00", k, clk_out[2], tick[2]); end
        end
        write_step(3'd2, 8'd3);
        total++; if ({pending[2], clk_out[2]} !== 2'b10) begin bad++; $display("FAIL ch2_wr3 got=%b%b exp=10", pending[2], clk_out[2]); end
        step();
        total++; if ({pending[2], clk_out[2]} !== 2'b00) begin bad++; $display("FAIL ch2_apply got=%b%b exp=00", pending[2], clk_out[2]); end
        for (int k = 1; k <= 12; k++) begin
            step();
            total++; if (clk_out[2] !== 1'((k / 3) % 2)) begin bad++; $display("FAIL ch2_clk k=%0d got=%b", k, clk_out[2]); end
            total++; if (tick[2] !== 1'(k % 6 == 3)) begin bad++; $display("FAIL ch2_tick k=%0d got=%b", k, tick[2]); end
        end
    endtask

    task automatic test_last_write_wins();
        while (ecnt % 16 != 2) step();
        write_step(3'd3, 8'd50);
        write_step(3'd3, 8'd4);
        write_step(3'd5, 8'd1);
        while (ecnt % 16 != 0) begin
            total++; if (pending !== 5'b01000) begin bad++; $display("FAIL ch3_pend e=%0d got=%b exp=%b", ecnt, pending, 5'b01000); end
            step();
        end
        total++; if ({pending[3], clk_out[3]} !== 2'b00) begin bad++; $display("FAIL ch3_apply got=%b%b exp=00", pending[3], clk_out[3]); end
        for (int k = 1; k <= 16; k++) begin
            step();
            total++; if (clk_out[3] !== 1'((k / 4) % 2)) begin bad++; $display("FAIL ch3_clk k=%0d got=%b", k, clk_out[3]); end
            total++; if (tick[3] !== 1'(k % 8 == 4)) begin bad++; $display("FAIL ch3_tick k=%0d got=%b", k, tick[3]); end
            total++; if ({clk_out[4], clk_out[0]} !== {2{1'((ecnt / 8) % 2)}}) begin bad++; $display("FAIL oor_clk e=%0d got=%b%b", ecnt, clk_out[4], clk_out[0]); end
        end
    endtask

    task automatic test_sync();
        logic [NCH-1:0] exp_c, exp_t;
        write_step(3'd1, 8'd8);
        write_step(3'd2, 8'd8);
        write_step(3'd3, 8'd8);
        sync = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if ({clk_out, tick, pending} !== 15'd0) begin bad++; $display("FAIL sync_hold k=%0d got=%b %b %b", k, clk_out, tick, pending); end
        end
        sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_c = (k >= 8 && k < 16) ? 5'b11111 : 5'b00000;
            exp_t = (k == 8) ? 5'b11111 : 5'b00000;
            total++; if (clk_out !== exp_c) begin bad++; $display("FAIL sync_clk k=%0d got=%b exp=%b", k, clk_out, exp_c); end
            total++; if (tick !== exp_t) begin bad++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
        end
    endtask

    task automatic test_reset_mid();
        logic [NCH-1:0] exp_c, exp_t;
        step(); step(); step();
        write_step(3'd0, 8'd25);
        total++; if (pending !== 5'b00001) begin bad++; $display("FAIL rm_pend got=%b exp=%b", pending, 5'b00001); end
        rst_n = 1'b0;
        step();
        total++; if ({clk_out, tick, pending} !== 15'd0) begin bad++; $display("FAIL rm_reset got=%b %b %b", clk_out, tick, pending); end
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_c = ((k / 8) % 2 == 1) ? 5'b11111 : 5'b00000;
            exp_t = (k % 16 == 8) ? 5'b11111 : 5'b00000;
            total++; if ({clk_out, tick, pending} !== {exp_c, exp_t, 5'b00000}) begin
                bad++; $display("FAIL rm_run k=%0d got=%b %b %b exp=%b %b 00000", k, clk_out, tick, pending, exp_c, exp_t);
            end
        end
    endtask

    task automatic test_h1();
        int waited = 0;
        write_step(3'd0, 8'd1);
        while (pending[0] === 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        total++; if (waited !== 15) begin bad++; $display("FAIL h1_apply_wait got=%0d exp=%0d", waited, 15); end
        total++; if (clk_out[0] !== 1'b0) begin bad++; $display("FAIL h1_start got=%b exp=0", clk_out[0]); end
        for (int k = 1; k <= 8; k++) begin
            step();
            total++; if ({clk_out[0], tick[0]} !== {2{1'(k % 2)}}) begin bad++; $display("FAIL h1_run k=%0d got=%b%b", k, clk_out[0], tick[0]); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_mid_period();
        test_disable();
        test_last_write_wins();
        test_sync();
        test_reset_mid();
        test_h1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_scaler_multi.md
Name: freq_scaler_multi

Overview:
- Parametrised multi-channel programmable clock-divider and tick generator. Replaces the fixed 50 MHz to 3.125 MHz scaler.
- Each channel produces a square-wave clock and a one-cycle tick (clock-enable). Both run at a runtime-programmable rate derived from clk_50M.
- Feeds the ADC controller, the RISC-V CPU enable, the algorithm timebase and the UART/PWM blocks.
- A global sync input phase-aligns all channels.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 8, width of the half-period value and the counter.
- DEF_HALF, 8, half-period loaded into every channel at reset. 8 gives 3.125 MHz from 50 MHz.

Ports:
- clk_50M, input, 1, system clock. All logic on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- sync, input, 1, restart and phase-align all channels.
- wr_en, input, 1, write strobe for a new half-period.
- wr_ch, input, $clog2(NUM_CH) (min 1), target channel index.
- wr_half, input, CNT_W, new half-period value in clk_50M cycles.
- clk_out, output, NUM_CH, per-channel divided clock, registered.
- tick, output, NUM_CH, per-channel one-cycle pulse, registered.
- pending, output, NUM_CH, high while a written value awaits application.

Behaviour:
- Per-channel state:
  - act_half: active half-period.
  - shd_half: shadow half-period.
  - cnt: CNT_W counter.
  - out: drives clk_out.
  - pend: drives pending.
- Reset (rst_n=0 at a rising edge):
  - act_half = shd_half = DEF_HALF.
  - cnt = 0, clk_out = 0, tick = 0, pending = 0.
  - Reset has priority over all other inputs. Reset mid-period discards any pending value.
- Running, act_half = H >= 1:
  - Each edge: if cnt == H-1, then cnt <= 0 and out <= ~out; otherwise cnt <= cnt+1.
  - Period = 2H cycles; duty cycle is exactly 50%.
  - Output frequency = 50 MHz / (2H).
- Tick:
  - tick[i] <= 1 on the same edge that out goes 0 to 1; 0 on every other edge.
  - The tick pulse is therefore coincident with the clk_out rising transition and lasts exactly one cycle.
- H = 1: clk_out toggles every cycle (25 MHz). tick is high every second cycle.
- H = 0: channel disabled. cnt holds 0, clk_out forced 0, tick 0.
- Latency after reset release with H = 8:
  - clk_out rises and tick pulses at the 8th rising edge after the first edge with rst_n = 1.
  - clk_out falls at the 16th edge.
- Write (wr_en = 1, wr_ch < NUM_CH): shd_half[wr_ch] <= wr_half and pend <= 1. Writes with wr_ch >= NUM_CH are ignored.
- Glitch-free update:
  - A pending value is applied only at the end of a full period: the edge where cnt == H-1 and out == 1 (the falling toggle).
  - On that edge: act_half <= shd_half, pend <= 0, cnt <= 0.
  - If act_half == 0, the pending value is applied on the next edge. The channel starts at cnt = 0, out = 0.
- Write on the same edge as the period end, same channel: the new wr_half is applied directly and pend stays 0. No period is ever truncated or stretched by an old value.
- Second write while pending: overwrites shd_half. The last write wins.
- sync = 1, all channels:
  - act_half <= shd_half (or wr_half, if a write to that channel occurs on the same edge).
  - cnt <= 0, out <= 0, tick <= 0, pend <= 0.
  - Held sync keeps all channels parked low.
  - After release, channels with equal H produce identical, edge-aligned waveforms.
- Priority: rst_n > sync > period-end update > counting.
- No combinational path from any input to any output.

Decomposition:
- Package freq_scaler_pkg:
  - Default constants: DEF_NUM_CH, DEF_CNT_W, DEF_HALF_3M125 = 8.
  - CH_W helper, max(1, $clog2(NUM_CH)).
  - Named half-period constants for the standard rates:
    - 3.125 MHz = 8
    - 1 MHz = 25
    - 500 kHz = 50
- Sub-module freq_scaler_ch: one channel.
  - Holds counter, shadow/active registers and update logic.
  - Ports: clk_50M, rst_n, sync, wr, wr_half, clk_out, tick, pending.
- Top level: a generate loop of NUM_CH instances plus wr_ch decode and range check.

Test Plan:
- Reset release, defaults: clk_out[0] rises at edge 8 with tick[0] = 1 for one cycle, falls at edge 16. Period is 16 cycles (3.125 MHz), and 1000 cycles of checking show 50% duty.
- Write ch1 wr_half = 25 mid-period: pending[1] = 1 until the current 16-cycle period completes. Then the period is 50 cycles, with no short or long half-period at the switch.
- Write ch2 wr_half = 0: the channel goes disabled after its current period (clk_out and tick stay 0). A later write of 3 restarts it with a 6-cycle period, rising 3 edges after application.
- Two writes to ch3 (50, then 4) within one period: only 4 is applied and pending[3] clears. An out-of-range wr_ch = NUM_CH changes nothing.
- Channels at H = 8 with arbitrary phase offsets, then sync pulsed for one cycle: all clk_out are 0 after the sync edge, and all rise together 8 edges later.
- rst_n asserted mid-period while a write is pending: the next edge has clk_out = 0, tick = 0, pending = 0. After release the default 16-cycle period resumes and the pending value is discarded.
